// File: rtl/stream_demultiplexer.sv
// One-to-N stream demultiplexer with a one-entry register per output channel.
// Targets come from select_lines (mode=0) or a round-robin pointer (mode=1).
module stream_demultiplexer #(
  parameter int DATA_WIDTH  = 8,
  parameter int NUM_OUTPUTS = 8,
  localparam int SEL_WIDTH  = $clog2(NUM_OUTPUTS)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              mode,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [DATA_WIDTH-1:0]             in_data,
  input  logic [SEL_WIDTH-1:0]              select_lines,
  output logic [NUM_OUTPUTS-1:0]            out_valid,
  input  logic [NUM_OUTPUTS-1:0]            out_ready,
  output logic [NUM_OUTPUTS*DATA_WIDTH-1:0] out_data,
  output logic [SEL_WIDTH-1:0]              rr_pointer,
  output logic                              drop_pulse
);

  logic [SEL_WIDTH-1:0]   target;
  logic [NUM_OUTPUTS-1:0] target_hit;
  logic                   in_range;
  logic                   target_open;
  logic                   accept;

  // An out-of-range select decodes to an all-zero hit vector, so it touches no channel.
  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    target     = mode ? rr_pointer : select_lines;
    target_hit = '0;
    for (int i = 0; i < NUM_OUTPUTS; i++) begin
      target_hit[i] = (target == SEL_WIDTH'(i));
    end
  end

  // The target can take a word if it is empty or is being drained on this edge.
  assign in_range    = |target_hit;
  assign target_open = |(target_hit & (~out_valid | out_ready));
  assign in_ready    = !rst && (!in_range || target_open);
  assign accept      = in_valid && in_ready;

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // sees the pre-edge values of its neighbours regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the data registers are reset as well, because out_data must read zero after reset.
      out_valid  <= '0;
      out_data   <= '0;
      rr_pointer <= '0;
      drop_pulse <= 1'b0;
    end else begin
      drop_pulse <= accept && !in_range;
      for (int i = 0; i < NUM_OUTPUTS; i++) begin
        if (accept && target_hit[i]) begin
          out_valid[i]                           <= 1'b1;
          out_data[i*DATA_WIDTH +: DATA_WIDTH]   <= in_data;
        end else if (out_ready[i]) begin
          out_valid[i] <= 1'b0;
        end
      end
      if (accept && mode) begin
        rr_pointer <= (rr_pointer == SEL_WIDTH'(NUM_OUTPUTS - 1)) ? '0
                                                                   : rr_pointer + SEL_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_stream_demultiplexer.sv
// Bench for stream_demultiplexer: an 8-channel and a 5-channel instance share stimulus.
// Directed tables and sequences, then random traffic against a queue-based model.
module tb_stream_demultiplexer;

  logic        clk = 1'b0;
  logic        rst;
  logic        mode;
  logic        in_valid;
  logic [7:0]  in_data;
  logic [2:0]  select_lines;
  logic [7:0]  out_ready;

  logic        in_ready;
  logic [7:0]  out_valid;
  logic [63:0] out_data;
  logic [2:0]  rr_pointer;
  logic        drop_pulse;

  logic        in_ready5;
  logic [4:0]  out_valid5;
  logic [39:0] out_data5;
  logic [2:0]  rr_pointer5;
  logic        drop_pulse5;

  int n_tests = 0;
  int n_fail  = 0;

  stream_demultiplexer #(.DATA_WIDTH(8), .NUM_OUTPUTS(8)) u_dut8 (
    .clk(clk), .rst(rst), .mode(mode), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .select_lines(select_lines), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .rr_pointer(rr_pointer),
    .drop_pulse(drop_pulse)
  );

  stream_demultiplexer #(.DATA_WIDTH(8), .NUM_OUTPUTS(5)) u_dut5 (
    .clk(clk), .rst(rst), .mode(mode), .in_valid(in_valid), .in_ready(in_ready5),
    .in_data(in_data), .select_lines(select_lines), .out_valid(out_valid5),
    .out_ready(out_ready[4:0]), .out_data(out_data5), .rr_pointer(rr_pointer5),
    .drop_pulse(drop_pulse5)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: each channel is a queue holding at most one word.
  bit   [7:0] mq    [2][8][$];
  logic [7:0] mlast [2][8];
  int         mrr   [2];
  bit         mdrop [2];
  int         nout  [2] = '{8, 5};

  task automatic model_reset(input int d);
    for (int i = 0; i < 8; i++) begin
      mq[d][i].delete();
      mlast[d][i] = 8'h00;
    end
    mrr[d]   = 0;
    mdrop[d] = 1'b0;
  endtask

  function automatic logic model_ready(input int d);
    int t;
    t = mode ? mrr[d] : int'(select_lines);
    if (rst) return 1'b0;
    if (t >= nout[d]) return 1'b1;
    return (mq[d][t].size() == 0) || out_ready[t];
  endfunction

  // Called with the pre-edge inputs applied; advances the model across one edge.
  task automatic model_step(input int d);
    int t;
    bit acc;
    bit [7:0] junk;
    t   = mode ? mrr[d] : int'(select_lines);
    acc = in_valid && model_ready(d);
    if (rst) begin
      model_reset(d);
      return;
    end
    for (int i = 0; i < nout[d]; i++) begin
      if (out_ready[i] && mq[d][i].size() > 0) junk = mq[d][i].pop_front();
    end
    if (acc && t < nout[d]) begin
      mq[d][t].push_back(in_data);
      mlast[d][t] = in_data;
    end
    mdrop[d] = acc && (t >= nout[d]);
    if (acc && mode) mrr[d] = (mrr[d] + 1) % nout[d];
  endtask

  task automatic model_check(input int d);
    logic [63:0] eov;
    logic [63:0] eod;
    eov = '0;
    eod = '0;
    for (int i = 0; i < nout[d]; i++) begin
      eov[i]         = (mq[d][i].size() > 0);
      eod[i*8 +: 8]  = mlast[d][i];
    end
    if (d == 0) begin
      check("rnd8 out_valid", out_valid, eov);
      check("rnd8 out_data", out_data, eod);
      check("rnd8 rr_pointer", rr_pointer, mrr[d]);
      check("rnd8 drop_pulse", drop_pulse, mdrop[d]);
    end else begin
      check("rnd5 out_valid", out_valid5, eov);
      check("rnd5 out_data", out_data5, eod);
      check("rnd5 rr_pointer", rr_pointer5, mrr[d]);
      check("rnd5 drop_pulse", drop_pulse5, mdrop[d]);
    end
  endtask

  typedef struct {
    logic       mode;
    logic [7:0] din;
    logic [2:0] sel;
    logic       exp_rdy;
    logic [7:0] exp_ov;
    int         exp_ch;
    logic [7:0] exp_dout;
    logic [2:0] exp_rr;
  } vec_t;

  vec_t vecs[18];

  initial begin
    // Explicit select 0..7 with 0xA0..0xA7, then ten round-robin words.
    for (int i = 0; i < 8; i++) begin
      vecs[i] = '{mode: 1'b0, din: 8'hA0 + 8'(i), sel: 3'(i), exp_rdy: 1'b1,
                  exp_ov: 8'(1 << i), exp_ch: i, exp_dout: 8'hA0 + 8'(i), exp_rr: 3'd0};
    end
    for (int j = 0; j < 10; j++) begin
      vecs[8 + j] = '{mode: 1'b1, din: 8'hC0 + 8'(j), sel: 3'(7 - (j % 8)), exp_rdy: 1'b1,
                      exp_ov: 8'(1 << (j % 8)), exp_ch: j % 8, exp_dout: 8'hC0 + 8'(j),
                      exp_rr: 3'((j + 1) % 8)};
    end

    // Reset: in_ready low while rst is high, everything cleared afterwards.
    rst = 1'b1; mode = 1'b0; in_valid = 1'b1; in_data = 8'h99; select_lines = 3'd0;
    out_ready = 8'h00;
    #1;
    check("reset in_ready", in_ready, 0);
    check("reset in_ready5", in_ready5, 0);
    tick();
    tick();
    check("reset out_valid", out_valid, 0);
    check("reset out_data", out_data, 0);
    check("reset rr_pointer", rr_pointer, 0);
    check("reset drop_pulse", drop_pulse, 0);
    rst = 1'b0; in_valid = 1'b0;
    tick();

    out_ready = 8'hFF;
    foreach (vecs[k]) begin
      mode = vecs[k].mode; in_valid = 1'b1; in_data = vecs[k].din; select_lines = vecs[k].sel;
      #1;
      check("table in_ready", in_ready, vecs[k].exp_rdy);
      tick();
      check("table out_valid", out_valid, vecs[k].exp_ov);
      check("table out_data", out_data[vecs[k].exp_ch*8 +: 8], vecs[k].exp_dout);
      check("table rr_pointer", rr_pointer, vecs[k].exp_rr);
    end
    in_valid = 1'b0;
    tick();
    check("table drained", out_valid, 0);
    check("table final rr", rr_pointer, 2);

    // Round-robin blocked on full channel 2 (filled in explicit mode; pointer holds at 2).
    mode = 1'b0; select_lines = 3'd2; in_data = 8'h33; in_valid = 1'b1; out_ready = 8'hFB;
    tick();
    check("rr fill out_valid", out_valid, 8'h04);
    check("rr fill rr held", rr_pointer, 2);
    mode = 1'b1; in_data = 8'h44;
    #1;
    check("rr blocked in_ready", in_ready, 0);
    for (int c = 0; c < 3; c++) begin
      tick();
      check("rr blocked in_ready", in_ready, 0);
      check("rr blocked pointer", rr_pointer, 2);
      check("rr blocked hold", out_data[2*8 +: 8], 8'h33);
    end
    out_ready = 8'hFF;
    #1;
    check("rr unblock in_ready", in_ready, 1);
    tick();
    check("rr unblock out_valid", out_valid, 8'h04);
    check("rr unblock data", out_data[2*8 +: 8], 8'h44);
    check("rr unblock pointer", rr_pointer, 3);
    in_valid = 1'b0;
    tick();
    check("rr drained", out_valid, 0);

    // Backpressure on channel 3, then fill-and-drain on one edge.
    mode = 1'b0; out_ready = 8'hF7; select_lines = 3'd3; in_data = 8'h11; in_valid = 1'b1;
    #1;
    check("bp first in_ready", in_ready, 1);
    tick();
    check("bp first out_valid", out_valid, 8'h08);
    check("bp first data", out_data[3*8 +: 8], 8'h11);
    in_data = 8'h22;
    #1;
    check("bp second in_ready", in_ready, 0);
    for (int c = 0; c < 2; c++) begin
      tick();
      check("bp hold out_valid", out_valid, 8'h08);
      check("bp hold data", out_data[3*8 +: 8], 8'h11);
      check("bp hold in_ready", in_ready, 0);
    end
    out_ready = 8'hFF;
    #1;
    check("bp release in_ready", in_ready, 1);
    tick();
    check("bp refill out_valid", out_valid, 8'h08);
    check("bp refill data", out_data[3*8 +: 8], 8'h22);
    in_valid = 1'b0;
    tick();
    check("bp drained", out_valid, 0);

    // Mid-stream reset with channels 0 and 4 full and pointer at 3.
    out_ready = 8'h00; select_lines = 3'd0; in_data = 8'h10; in_valid = 1'b1;
    tick();
    select_lines = 3'd4; in_data = 8'h40;
    tick();
    in_valid = 1'b0;
    check("prereset out_valid", out_valid, 8'h11);
    check("prereset rr_pointer", rr_pointer, 3);
    rst = 1'b1; in_valid = 1'b1; select_lines = 3'd1; in_data = 8'h77;
    #1;
    check("midreset in_ready", in_ready, 0);
    tick();
    check("midreset out_valid", out_valid, 0);
    check("midreset rr_pointer", rr_pointer, 0);
    check("midreset out_data", out_data, 0);
    check("midreset drop", drop_pulse, 0);
    rst = 1'b0; in_valid = 1'b0;
    tick();

    // Out-of-range selects on the 5-channel instance.
    out_ready = 8'h00; mode = 1'b0; select_lines = 3'd1; in_data = 8'h21; in_valid = 1'b1;
    tick();
    check("drop5 prefill out_valid", out_valid5, 5'h02);
    select_lines = 3'd6; in_data = 8'h5A;
    #1;
    check("drop5 sel6 in_ready", in_ready5, 1);
    tick();
    check("drop5 sel6 pulse", drop_pulse5, 1);
    check("drop5 sel6 out_valid", out_valid5, 5'h02);
    check("drop5 sel6 out_data", out_data5, 40'h00_00_00_21_00);
    in_valid = 1'b0;
    tick();
    check("drop5 pulse width", drop_pulse5, 0);
    check("drop5 out_valid kept", out_valid5, 5'h02);
    select_lines = 3'd5; in_data = 8'h55; in_valid = 1'b1;
    #1;
    check("drop5 sel5 in_ready", in_ready5, 1);
    tick();
    check("drop5 sel5 pulse", drop_pulse5, 1);
    check("drop5 sel5 out_valid", out_valid5, 5'h02);
    select_lines = 3'd4; in_data = 8'h44;
    tick();
    check("drop5 sel4 no pulse", drop_pulse5, 0);
    check("drop5 sel4 out_valid", out_valid5, 5'h12);
    check("drop5 sel4 data", out_data5[4*8 +: 8], 8'h44);
    in_valid = 1'b0;
    tick();

    // Random traffic against the model, including occasional mid-stream resets.
    for (int c = 0; c < 800; c++) begin
      rst          = (c == 0) || ($urandom_range(0, 60) == 0);
      mode         = 1'($urandom_range(0, 1));
      in_valid     = ($urandom_range(0, 3) != 0);
      in_data      = 8'($urandom);
      select_lines = 3'($urandom);
      for (int i = 0; i < 8; i++) out_ready[i] = ($urandom_range(0, 9) < 6);
      #1;
      check("rnd8 in_ready", in_ready, model_ready(0));
      check("rnd5 in_ready", in_ready5, model_ready(1));
      model_step(0);
      model_step(1);
      tick();
      model_check(0);
      model_check(1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
